// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel end of the UART link.
//   Frame format: start(0), 8 data bits LSB first, even parity, stop(1).
//   A 16x oversample tick is derived from baud_select. The frame is validated,
//   and the result is presented as one byte plus a one-cycle status pulse.
//
//   Optional feature: define RX_MAJORITY_VOTE_EN to take each bit as the majority
//   of ticks 7,8,9. Without it, each bit is a single sample at tick 8.
//
// Ports
//   clock        in   1  system clock, all logic on posedge
//   reset        in   1  asynchronous, active-low reset
//   baud_select  in   3  000..111 -> 300,1200,4800,9600,19200,38400,57600,115200
//   Rx_EN        in   1  receiver enable; 0 ignores the line and aborts a frame
//   RxD          in   1  serial line, asynchronous, idle high
//   Rx_DATA      out  8  last correctly framed byte
//   Rx_VALID     out  1  one-cycle pulse: byte received, parity and stop OK
//   Rx_PERROR    out  1  one-cycle pulse: parity mismatch
//   Rx_FERROR    out  1  one-cycle pulse: stop bit sampled 0
`timescale 1ns/1ps
module uart_receiver #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned OSR    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   // The slowest rate (300 baud) sets the divisor counter width.
   localparam int unsigned DIV_W = $clog2(CLK_HZ / (OSR * 300) + 2);
   localparam int unsigned TCK_W = $clog2(OSR);
   localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OSR - 1);

   // The tick counter holds the position inside the current bit. Index k-1
   // means the k-th tick of that bit has just arrived.
`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [TCK_W-1:0] VOTE_A   = TCK_W'(OSR / 2 - 2);
   localparam logic [TCK_W-1:0] VOTE_B   = TCK_W'(OSR / 2 - 1);
   localparam logic [TCK_W-1:0] DEC_TICK = TCK_W'(OSR / 2);
`else
   localparam logic [TCK_W-1:0] DEC_TICK = TCK_W'(OSR / 2 - 1);
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // divisor = round(CLK_HZ / (OSR * baud))
   function automatic logic [DIV_W-1:0] divisor(input logic [2:0] sel);
      int unsigned baud;
      case (sel)
         3'd0:    baud = 300;
         3'd1:    baud = 1200;
         3'd2:    baud = 4800;
         3'd3:    baud = 9600;
         3'd4:    baud = 19200;
         3'd5:    baud = 38400;
         3'd6:    baud = 57600;
         default: baud = 115200;
      endcase
      return DIV_W'((CLK_HZ + (OSR / 2) * baud) / (OSR * baud));
   endfunction

   logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
   state_t           state_q;
   logic [2:0]       baud_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [TCK_W-1:0] tick_cnt_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             perr_q;
   logic [7:0]       data_q;
   logic             valid_q, perror_q, ferror_q;
`ifdef RX_MAJORITY_VOTE_EN
   logic [1:0]       vote_q;
`endif

   logic [DIV_W-1:0] div_max;
   logic             tick;
   logic             sample_at;
   logic             bit_d;

   always_comb begin
      div_max   = divisor(baud_q);
      tick      = (state_q != IDLE) && (div_cnt_q == div_max - DIV_W'(1));
      sample_at = tick && (tick_cnt_q == DEC_TICK);
`ifdef RX_MAJORITY_VOTE_EN
      // The third vote is the line value at the decision tick itself.
      bit_d = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_sync_q) | (vote_q[1] & rxd_sync_q);
`else
      bit_d = rxd_sync_q;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
         state_q    <= IDLE;
         baud_q     <= '0;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perror_q   <= 1'b0;
         ferror_q   <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
         vote_q     <= '0;
`endif
      end else begin
         rxd_meta_q <= RxD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
         valid_q    <= 1'b0;
         perror_q   <= 1'b0;
         ferror_q   <= 1'b0;

         if (state_q != IDLE) begin
            if (tick) begin
               div_cnt_q  <= '0;
               tick_cnt_q <= (tick_cnt_q == TCK_LAST) ? '0 : tick_cnt_q + TCK_W'(1);
            end else begin
               div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
`ifdef RX_MAJORITY_VOTE_EN
            if (tick && tick_cnt_q == VOTE_A) vote_q[0] <= rxd_sync_q;
            if (tick && tick_cnt_q == VOTE_B) vote_q[1] <= rxd_sync_q;
`endif
         end

         if (!Rx_EN) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  // A falling edge is required, so a held-low line (break) never restarts.
                  if (rxd_prev_q && !rxd_sync_q) begin
                     state_q    <= START;
                     baud_q     <= baud_select;
                     div_cnt_q  <= '0;
                     tick_cnt_q <= '0;
                     bit_cnt_q  <= '0;
                  end
               end
               START: if (sample_at) state_q <= bit_d ? IDLE : DATA;
               DATA: begin
                  if (sample_at) begin
                     shift_q   <= {bit_d, shift_q[7:1]};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) state_q <= PARITY;
                  end
               end
               PARITY: begin
                  if (sample_at) begin
                     perr_q  <= (^shift_q) ^ bit_d;
                     state_q <= STOP;
                  end
               end
               STOP: begin
                  if (sample_at) begin
                     if (!bit_d) begin
                        ferror_q <= 1'b1;
                     end else if (perr_q) begin
                        perror_q <= 1'b1;
                     end else begin
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                     end
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_PERROR = perror_q;
   assign Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed frames driven onto RxD, with hand-computed expected bytes and flags.
//   A monitor counts status pulses and logs every valid byte.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int CLK_NS   = 20;            // 50 MHz
   localparam int BIT_FAST = 27 * 16;       // 115200 baud, clocks per bit
   localparam int BIT_SLOW = 326 * 16;      // 9600 baud, clocks per bit

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] baud_select = 3'b111;
   logic       Rx_EN = 1'b0;
   logic       RxD = 1'b1;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         vld_cnt  = 0;
   int         perr_cnt = 0;
   int         ferr_cnt = 0;
   logic [7:0] vld_log[$];
   time        vld_time = 0;

   always #(CLK_NS / 2) clock = ~clock;

   uart_receiver dut (
      .clock      (clock),
      .reset      (reset),
      .baud_select(baud_select),
      .Rx_EN      (Rx_EN),
      .RxD        (RxD),
      .Rx_DATA    (Rx_DATA),
      .Rx_VALID   (Rx_VALID),
      .Rx_PERROR  (Rx_PERROR),
      .Rx_FERROR  (Rx_FERROR)
   );

   // Each cycle a flag stays high counts once, so a stretched pulse shows up as an extra count.
   always @(negedge clock) begin
      if (Rx_VALID) begin
         vld_cnt++;
         vld_log.push_back(Rx_DATA);
         vld_time = $time;
      end
      if (Rx_PERROR) perr_cnt++;
      if (Rx_FERROR) ferr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   // Drives frame bits first..last, each held for bitclk clocks. The caller must be at a negedge.
   task automatic send_bits(input logic [10:0] fr, input int first, input int last, input int bitclk);
      for (int i = first; i <= last; i++) begin
         RxD = fr[i];
         repeat (bitclk) @(negedge clock);
      end
   endtask

   task automatic check_flags(input string tag, input int v0, input int p0, input int f0,
                              input int ev, input int ep, input int ef);
      check({tag, "_valid"},  32'(vld_cnt - v0),  32'(ev));
      check({tag, "_perror"}, 32'(perr_cnt - p0), 32'(ep));
      check({tag, "_ferror"}, 32'(ferr_cnt - f0), 32'(ef));
   endtask

   initial begin
      int         v0, p0, f0, n0;
      time        t0;
      int         lat;
      logic [10:0] fr;

      // Reset state
      repeat (5) @(negedge clock);
      check("rst_data",   32'(Rx_DATA),   32'h00);
      check("rst_valid",  32'(Rx_VALID),  32'h0);
      check("rst_perror", 32'(Rx_PERROR), 32'h0);
      check("rst_ferror", 32'(Rx_FERROR), 32'h0);
      reset = 1'b1;
      Rx_EN = 1'b1;
      repeat (20) @(negedge clock);

      // 0xA5 at 115200 (four ones -> even parity bit 0)
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      t0 = $time;
      send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 0, 10, BIT_FAST);
      repeat (20) @(negedge clock);
      check_flags("a5", v0, p0, f0, 1, 0, 0);
      check("a5_data", 32'(Rx_DATA), 32'hA5);
      // The stop-bit midpoint lies 10.5 bit periods (4536 clocks) after the start edge,
      // plus a few clocks of synchronizer and edge detection.
      lat = int'((vld_time - t0) / CLK_NS);
      check("a5_latency_window", 32'((lat >= 4536) && (lat <= 4546)), 32'h1);

      // 0x01 at 9600 with parity 0 (one one -> parity should be 1)
      baud_select = 3'b011;
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_bits(mk_frame(8'h01, 1'b0, 1'b1), 0, 9, BIT_SLOW);
      RxD = 1'b1;
      repeat (BIT_SLOW / 2 + 50) @(negedge clock);
      baud_select = 3'b111;
      check_flags("perr", v0, p0, f0, 0, 1, 0);
      check("perr_data_held", 32'(Rx_DATA), 32'hA5);

      // 0x3C with correct parity but stop bit 0
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 0, 10, BIT_FAST);
      RxD = 1'b1;
      repeat (50) @(negedge clock);
      check_flags("ferr", v0, p0, f0, 0, 0, 1);
      check("ferr_data_held", 32'(Rx_DATA), 32'hA5);

      // Short low glitch of 100 clocks: start rejected at the midpoint
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      RxD = 1'b0;
      repeat (100) @(negedge clock);
      RxD = 1'b1;
      repeat (500) @(negedge clock);
      check_flags("glitch", v0, p0, f0, 0, 0, 0);

      // 0x5A; baud_select changes mid-frame and must be ignored
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      fr = mk_frame(8'h5A, 1'b0, 1'b1);
      send_bits(fr, 0, 2, BIT_FAST);
      baud_select = 3'b000;
      send_bits(fr, 3, 10, BIT_FAST);
      baud_select = 3'b111;
      repeat (20) @(negedge clock);
      check_flags("5a", v0, p0, f0, 1, 0, 0);
      check("5a_data", 32'(Rx_DATA), 32'h5A);

      // Back-to-back frames 0x00, 0xFF, then 0x1E (asymmetric, catches bit order)
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      n0 = vld_log.size();
      send_bits(mk_frame(8'h00, 1'b0, 1'b1), 0, 10, BIT_FAST);
      send_bits(mk_frame(8'hFF, 1'b0, 1'b1), 0, 10, BIT_FAST);
      send_bits(mk_frame(8'h1E, 1'b0, 1'b1), 0, 10, BIT_FAST);
      repeat (20) @(negedge clock);
      check_flags("b2b", v0, p0, f0, 3, 0, 0);
      check("b2b_log_size", 32'(vld_log.size() - n0), 32'd3);
      if (vld_log.size() >= n0 + 3) begin
         check("b2b_first",  32'(vld_log[n0]),     32'h00);
         check("b2b_second", 32'(vld_log[n0 + 1]), 32'hFF);
         check("b2b_third",  32'(vld_log[n0 + 2]), 32'h1E);
      end
      check("b2b_data", 32'(Rx_DATA), 32'h1E);

      // 0x77: Rx_EN drops after four data bits; the rest of the frame must be ignored
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      fr = mk_frame(8'h77, 1'b0, 1'b1);
      send_bits(fr, 0, 4, BIT_FAST);
      Rx_EN = 1'b0;
      send_bits(fr, 5, 10, BIT_FAST);
      RxD = 1'b1;
      repeat (BIT_FAST) @(negedge clock);
      check_flags("disable", v0, p0, f0, 0, 0, 0);
      check("disable_data_held", 32'(Rx_DATA), 32'h1E);

      // Reset in the middle of a frame
      Rx_EN = 1'b1;
      repeat (50) @(negedge clock);
      v0 = vld_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_bits(fr, 0, 3, BIT_FAST);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("midrst_data",   32'(Rx_DATA),   32'h00);
      check("midrst_valid",  32'(Rx_VALID),  32'h0);
      check("midrst_perror", 32'(Rx_PERROR), 32'h0);
      check("midrst_ferror", 32'(Rx_FERROR), 32'h0);
      reset = 1'b1;
      RxD = 1'b1;
      repeat (BIT_FAST) @(negedge clock);
      check_flags("midrst", v0, p0, f0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
